// File: rtl/chacha_keystream_sched_pkg.sv
// Shared widths and FSM encoding for the ChaCha keystream scheduler.
package chacha_keystream_sched_pkg;
  localparam int CHACHA_KEY_W    = 256;
  localparam int NONCE_W         = 96;
  localparam int CTR_W           = 32;
  localparam int BLOCK_W         = 512;
  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FLUSH = 2'd3
  } sched_state_t;
endpackage

// File: rtl/chacha_keystream_sched_if.sv
// Keystream word stream between the scheduler and the cipher front end.
interface chacha_keystream_sched_if;
  import chacha_keystream_sched_pkg::*;

  logic [WORD_W-1:0] ks_word_o;
  logic              ks_valid_o;
  logic              ks_ready_i;

  modport master (output ks_word_o, ks_valid_o, input ks_ready_i);
  modport slave  (input ks_word_o, ks_valid_o, output ks_ready_i);
endinterface

// File: rtl/chacha_keystream_sched_serializer.sv
// Hold register plus output buffer; drains 512-bit blocks MSW first as 32-bit words.
module chacha_keystream_sched_serializer
  import chacha_keystream_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               cap,
  input  logic [BLOCK_W-1:0] cap_data,
  output logic               hold_full,
  output logic               move,
  output logic               last_xfer,
  chacha_keystream_sched_if.master ks
);
  logic [BLOCK_W-1:0] data_q;
  logic [BLOCK_W-1:0] hold_q;
  logic               data_full_q;
  logic               hold_full_q;
  logic [3:0]         idx_q;
  logic               xfer;

  assign xfer      = data_full_q & ks.ks_ready_i;
  assign last_xfer = xfer & (idx_q == 4'(WORDS_PER_BLOCK - 1));
  // Reload in the same cycle the last word leaves so back-to-back blocks have no bubble.
  assign move      = hold_full_q & (~data_full_q | last_xfer);
  assign hold_full = hold_full_q;

  assign ks.ks_valid_o = data_full_q;
  assign ks.ks_word_o  = data_q[BLOCK_W-1 -: WORD_W];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      data_q      <= '0;
      hold_q      <= '0;
      data_full_q <= 1'b0;
      hold_full_q <= 1'b0;
      idx_q       <= '0;
    end else begin
      if (move) begin
        data_q      <= hold_q;
        data_full_q <= 1'b1;
        idx_q       <= '0;
      end else if (xfer) begin
        data_q <= data_q << WORD_W;
        idx_q  <= idx_q + 4'd1;
        if (last_xfer) data_full_q <= 1'b0;
      end

      if (move) begin
        hold_full_q <= 1'b0;
      end else if (cap && !hold_full_q) begin
        hold_q      <= cap_data;
        hold_full_q <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/chacha_keystream_sched.sv
// Runs one ChaCha block core over a span of counters and streams the keystream out.
//   state    | meaning
//   ST_IDLE  | no run; accepts start when the core is ready
//   ST_ISSUE | pulse core start with the current counter
//   ST_WAIT  | wait for core done, then hand block to the output buffer
//   ST_FLUSH | last block draining; pulse run_done after its final word
module chacha_keystream_sched
  import chacha_keystream_sched_pkg::*;
#(
  parameter int MAX_BLOCKS_W = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [CHACHA_KEY_W-1:0] key_i,
  input  logic [NONCE_W-1:0]      nonce_i,
  input  logic [CTR_W-1:0]        counter_i,
  input  logic [MAX_BLOCKS_W-1:0] nblocks_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  output logic                    busy_o,
  output logic                    run_done_o,
  output logic                    err_o,
  chacha_keystream_sched_if.master ks,
  output logic [CHACHA_KEY_W-1:0] core_key_o,
  output logic [NONCE_W-1:0]      core_nonce_o,
  output logic [CTR_W-1:0]        core_counter_o,
  output logic                    core_start_o,
  input  logic [BLOCK_W-1:0]      core_ks_i,
  input  logic                    core_done_i,
  input  logic                    core_ready_i
);
  sched_state_t            state_q, state_d;
  logic [CTR_W-1:0]        ctr_q, ctr_d;
  logic [MAX_BLOCKS_W-1:0] rem_q, rem_d;
  logic [CHACHA_KEY_W-1:0] key_q;
  logic [NONCE_W-1:0]      nonce_q;
  logic                    err_q, err_d;
  logic                    done_q, done_d;
  logic                    load;
  logic                    cap;
  logic                    move;
  logic                    last_xfer;
  logic                    hold_full;
  logic                    reject;

  // Last counter of the run must still fit in 32 bits: counter + n - 1 <= 2^32 - 1.
  assign reject = (nblocks_i == '0) |
                  (({1'b0, counter_i} + 33'(nblocks_i)) > 33'h1_0000_0000);

  always_comb begin
    state_d      = state_q;
    ctr_d        = ctr_q;
    rem_d        = rem_q;
    err_d        = 1'b0;
    done_d       = 1'b0;
    load         = 1'b0;
    cap          = 1'b0;
    core_start_o = 1'b0;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i && core_ready_i) begin
            if (reject) begin
              err_d = 1'b1;
            end else begin
              load    = 1'b1;
              ctr_d   = counter_i;
              rem_d   = nblocks_i;
              state_d = ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (core_ready_i) begin
            core_start_o = 1'b1;
            state_d      = ST_WAIT;
          end
        end
        ST_WAIT: begin
          cap = core_done_i & ~hold_full;
          if (move) begin
            ctr_d   = ctr_q + CTR_W'(1);
            rem_d   = rem_q - MAX_BLOCKS_W'(1);
            state_d = (rem_q == MAX_BLOCKS_W'(1)) ? ST_FLUSH : ST_ISSUE;
          end
        end
        ST_FLUSH: begin
          if (last_xfer) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ctr_q   <= '0;
      rem_q   <= '0;
      key_q   <= '0;
      nonce_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      done_q  <= done_d;
      if (load) begin
        key_q   <= key_i;
        nonce_q <= nonce_i;
      end
    end
  end

  chacha_keystream_sched_serializer u_ser (
    .clk       (clk_i),
    .rst       (rst_i),
    .flush     (abort_i),
    .cap       (cap),
    .cap_data  (core_ks_i),
    .hold_full (hold_full),
    .move      (move),
    .last_xfer (last_xfer),
    .ks        (ks)
  );

  assign core_key_o     = key_q;
  assign core_nonce_o   = nonce_q;
  assign core_counter_o = ctr_q;
  assign busy_o         = (state_q != ST_IDLE) | ~core_ready_i;
  assign run_done_o     = done_q;
  assign err_o          = err_q;
endmodule
